imem_loader: RTL and testbench
==============================

# imem_loader

Writable instruction memory with a byte-stream program loader for the single-cycle processor. It accepts a program as a valid/ready byte stream and assembles big-endian 32-bit instruction words. It writes them into a 16-entry instruction store and serves the processor's combinational fetch port, replacing the hard-coded initial program. The processor is held off with `busy` while a load is in progress.

## Interface
- `DEPTH`, 16, number of 32-bit instruction words
- `ADDR_W`, 4, word-address width, equal to log2(DEPTH)

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle request to begin a load
- `count`  in  ADDR_W+1  number of words to load, sampled with `start`
- `in_data`  in  8  program byte
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts a byte this cycle
- `index`  in  32  fetch word index, same meaning as the processor PC word index
- `instr`  out  32  instruction word at `index`
- `busy`  out  1  load in progress; processor must stall
- `done`  out  1  last load completed
- `err`  out  1  one-cycle pulse: illegal `count` on `start`

## Operation
- States are IDLE, LOAD and DONE.
- **Reset (`rst_n`=0 at an edge):**
  - state becomes IDLE.
  - All DEPTH words are cleared to 0, which is the NOP `sll r0,r0,0`.
  - Byte counter, word pointer and assembly register are cleared.
  - Outputs: `in_ready`=0, `busy`=0, `done`=0, `err`=0.
- **IDLE or DONE, `start`=1:**
  - If `count` is in 1..DEPTH: latch `count`, clear word pointer and byte counter, go to LOAD, and clear `done`.
  - If `count`=0 or `count`>DEPTH: state is unchanged and `err` pulses for one cycle.
- **LOAD:**
  - `in_ready`=1 and `busy`=1.
  - A byte is accepted when `in_valid` and `in_ready` are both 1.
  - Byte order is big-endian: the first byte fills bits [31:24] and the fourth fills bits [7:0].
  - On the 4th accepted byte, the full word (assembled word plus the current byte) is written to RAM[word pointer] at that edge. The word pointer then increments and the byte counter wraps to 0.
  - When the written word is number `count`, the next state is DONE.
  - `start` is ignored in LOAD; it does not raise `err`.
- **DONE:** `in_ready`=0, `busy`=0, `done`=1. This holds until the next legal `start`.
- **Fetch port:**
  - `instr` is RAM[`index`[ADDR_W-1:0]], combinational.
  - If `index` ≥ DEPTH, `instr`=0.
  - Words not written by the current load keep their previous contents.
- **Reset mid-load:** the partial word is discarded, the RAM is cleared and the state is IDLE. No partial write ever occurs.

## Timing
- `in_ready`, `busy` and `done` decode directly from the state register, with no combinational path from `in_valid`.
- A written word is visible on `instr` in the cycle after its write edge. Same-cycle fetch of the address being written returns the old word.
- `done` rises on the cycle after the edge that accepts the final byte.
- Load duration is at least 4×`count` cycles, plus one cycle of entry latency after `start`. Stalls on `in_valid` extend it with no loss of data.
- `err` is registered and asserts in the cycle after the offending `start`.
- The longest legal load is DEPTH×4 = 64 accepted bytes.

## Structure
- **Shared package `imem_pkg`:** holds the `DEPTH` and `ADDR_W` defaults, the state enumeration (IDLE, LOAD, DONE) and the `INSTR_NOP` = 32'h0000_0000 constant.
- **Sub-module `imem_ram`:** DEPTH×32 storage with one synchronous write port, one asynchronous read port and a synchronous clear.
- **`imem_loader`:** holds the FSM, byte counter, word pointer, assembly register, `count` latch and out-of-range read masking.

## Test plan
1. **Reset:** apply reset, then read indices 0..15 → `instr`=0 for every index; `busy`=`done`=`in_ready`=0.
2. **Single-word load:** `start` with `count`=1, then send bytes 00,01,10,20 with continuous valid → RAM[0]=32'h00011020 (`add r2,r0,r1`); `done`=1 one cycle after the 4th byte; `instr` at `index`=1 is still 0.
3. **Full load with stalls:** `count`=16, 64 bytes with `in_valid` toggling randomly → every word matches the expected big-endian assembly; `busy` stays high throughout; the byte count is exactly 64 when `done` rises.
4. **Illegal count:** `start` with `count`=0, then with `count`=17 → `err` pulses for one cycle each time; state stays IDLE; `in_ready`=0.
5. **Reset and start mid-load:** `count`=3; after 6 bytes, assert `start` → it is ignored. Then assert `rst_n`=0 → all words read 0, state is IDLE, and no write has occurred to word 1.
6. **Reload and out-of-range read:**
   - Load `count`=2 with words 8CC40001 and AC C40002 (bytes 8C C4 00 01 AC C4 00 02), then reload `count`=1 with 20070007 → word0=20070007, word1=ACC40002.
   - `index`=16 → `instr`=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the writable instruction memory and its loader.
package imem_pkg;

   localparam int          IMEM_DEPTH  = 16;
   localparam int          IMEM_ADDR_W = 4;

   // All-zero word decodes as sll r0,r0,0, so cleared memory executes NOPs.
   localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction store: one synchronous write port, one asynchronous
// read port and a synchronous clear that wins over a write.
module imem_ram
   import imem_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk_i,
   input  logic              clr_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // Clear every word, otherwise write the addressed word.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= INSTR_NOP;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read is combinational; a same-cycle write shows up only after the edge.
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader. Bytes arrive on a
// valid/ready stream, are packed big-endian into 32-bit words and written to
// consecutive words starting at 0. The processor fetches combinationally and
// is stalled through busy_o while a load runs.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [ADDR_W:0]   count_i,
   input  logic [7:0]        in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [31:0]       index_i,
   output logic [31:0]       instr_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q,   cnt_d;    // words requested by this load
   logic [ADDR_W:0]   wptr_q,  wptr_d;   // next word to write; one bit wider so it can reach DEPTH
   logic [1:0]        byte_q,  byte_d;   // bytes already held in asm_q
   logic [23:0]       asm_q,   asm_d;    // first three bytes of the word being built
   logic              err_q,   err_d;

   logic              count_ok;
   logic              accept;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   assign count_ok   = (count_i != '0) && (count_i <= DEPTH_C);

   // Handshake outputs come straight from the state register.
   assign in_ready_o = (state_q == ST_LOAD);
   assign busy_o     = (state_q == ST_LOAD);
   assign done_o     = (state_q == ST_DONE);
   assign err_o      = err_q;
   assign accept     = in_valid_i && in_ready_o;

   // Register all loader state; reset also clears the RAM through clr_i.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wptr_q  <= '0;
         byte_q  <= '0;
         asm_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         byte_q  <= byte_d;
         asm_q   <= asm_d;
         err_q   <= err_d;
      end
   end

   // Next-state: start handling, byte assembly and the word write strobe.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wptr_d    = wptr_q;
      byte_d    = byte_q;
      asm_d     = asm_q;
      err_d     = 1'b0;
      ram_we    = 1'b0;
      ram_wdata = {asm_q, in_data_i};

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               if (count_ok) begin
                  cnt_d   = count_i;
                  wptr_d  = '0;
                  byte_d  = '0;
                  asm_d   = '0;
                  state_d = ST_LOAD;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            // start_i is deliberately ignored here.
            if (accept) begin
               if (byte_q == 2'd3) begin
                  // Fourth byte completes the word; write it in full this edge.
                  ram_we = 1'b1;
                  wptr_d = wptr_q + ONE_C;
                  byte_d = '0;
                  asm_d  = '0;
                  if (wptr_q + ONE_C == cnt_q) state_d = ST_DONE;
               end else begin
                  // Shift left so the first byte ends up in bits [31:24].
                  asm_d  = {asm_q[15:0], in_data_i};
                  byte_d = byte_q + 2'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   imem_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk_i),
      .clr_i   (!rst_n_i),
      .we_i    (ram_we),
      .waddr_i (wptr_q[ADDR_W-1:0]),
      .wdata_i (ram_wdata),
      .raddr_i (index_i[ADDR_W-1:0]),
      .rdata_o (ram_rdata)
   );

   // Indices past the store read as NOP rather than aliasing.
   assign instr_o = (index_i >= 32'(DEPTH)) ? INSTR_NOP : ram_rdata;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized byte streams, a word-array reference
// memory, and a scoreboard of expected done/err events checked by a monitor.
module tb_imem_loader;
   import imem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  count = '0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] index = '0;
   logic [31:0] instr;
   logic        busy, done, err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   logic [31:0] model [16];
   int          done_q [$];   // word count of each load expected to finish
   int          err_q  [$];   // cycle of each start expected to raise err

   imem_loader dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .count_i    (count),
      .in_data_i  (in_data),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .index_i    (index),
      .instr_o    (instr),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops an expectation each time the DUT reports done or err.
   initial begin
      int  nb;
      int  last_acc;
      int  e;
      logic done_prev;
      nb = 0; last_acc = -10; done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            nb = 0; done_prev = 1'b0;
            continue;
         end
         if (err) begin
            if (err_q.size() == 0) chk("err_unexpected", 32'(err), 32'd0);
            else begin
               e = err_q.pop_front();
               chk("err_cycle", 32'(cyc), 32'(e + 1));
               chk("err_no_ready", 32'(in_ready), 32'd0);
            end
         end
         if (done && !done_prev) begin
            if (done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
            else begin
               e = done_q.pop_front();
               chk("done_bytes", 32'(nb), 32'(4 * e));
               chk("done_latency", 32'(cyc), 32'(last_acc + 1));
            end
            nb = 0;
         end
         done_prev = done;
         if (in_valid && in_ready) begin
            nb++;
            last_acc = cyc;
         end
      end
   end

   task automatic do_reset();
      start = 1'b0; in_valid = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      done_q.delete();
      err_q.delete();
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
   endtask

   // Reads every word through the fetch port plus two out-of-range indices.
   task automatic sweep(input string name);
      for (int i = 0; i < 16; i++) begin
         index = i;
         @(negedge clk);
         chk($sformatf("%s_w%0d", name, i), instr, model[i]);
         tick();
      end
      index = 16;
      @(negedge clk);
      chk({name, "_idx16"}, instr, 32'h0);
      tick();
      index = $urandom | 32'h0001_0000;
      @(negedge clk);
      chk({name, "_idxbig"}, instr, 32'h0);
      tick();
      index = 0;
   endtask

   task automatic issue_start(input int c);
      start = 1'b1;
      count = 5'(c);
      if (c >= 1 && c <= 16) done_q.push_back(c);
      else err_q.push_back(cyc);
      tick();
      start = 1'b0;
   endtask

   // Offers bytes with random gaps on in_valid; busy must hold throughout.
   task automatic send(input logic [7:0] bq [$], input int stall);
      int i = 0;
      int guard = 0;
      while (i < bq.size()) begin
         in_data  = bq[i];
         in_valid = ($urandom_range(99) >= stall);
         @(negedge clk);
         if (in_valid && in_ready) i++;
         if (in_valid) chk("busy_in_load", 32'(busy), 32'd1);
         tick();
         guard++;
         if (guard > 3000) begin
            chk("send_timeout", 32'(i), 32'(bq.size()));
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((done_q.size() != 0 || err_q.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      chk("sb_drain", 32'(done_q.size() + err_q.size()), 32'd0);
   endtask

   // Reference: word k = bytes 4k..4k+3 weighted most-significant first.
   task automatic model_load(input logic [7:0] bq [$]);
      for (int k = 0; k < bq.size() / 4; k++)
         model[k] = bq[4*k] * 32'h0100_0000 + bq[4*k+1] * 32'h1_0000
                  + bq[4*k+2] * 32'h100 + 32'(bq[4*k+3]);
   endtask

   task automatic load(input int c, input logic [7:0] bq [$], input int stall);
      issue_start(c);
      send(bq, stall);
      model_load(bq);
      drain();
      @(negedge clk);
      chk("done_after_load", 32'(done), 32'd1);
      chk("busy_after_load", 32'(busy), 32'd0);
      chk("ready_after_load", 32'(in_ready), 32'd0);
      tick();
   endtask

   initial begin
      logic [7:0] bq [$];
      int c;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();
      sweep("reset");

      // Illegal counts from IDLE
      issue_start(0);
      @(negedge clk);
      chk("ill0_busy", 32'(busy), 32'd0);
      chk("ill0_done", 32'(done), 32'd0);
      tick();
      issue_start(17);
      @(negedge clk);
      chk("ill17_ready", 32'(in_ready), 32'd0);
      tick();
      issue_start(31);
      drain();

      // Single word: add r2,r0,r1
      bq = '{8'h00, 8'h01, 8'h10, 8'h20};
      load(1, bq, 0);
      index = 0;
      @(negedge clk);
      chk("single_w0", instr, 32'h0001_1020);
      index = 1;
      @(negedge clk);
      chk("single_w1", instr, 32'h0);
      tick();

      // Full depth with random stalls
      bq.delete();
      for (int i = 0; i < 64; i++) bq.push_back(8'($urandom));
      load(16, bq, 45);
      sweep("full");

      // Illegal start while DONE keeps DONE
      issue_start(0);
      drain();
      @(negedge clk);
      chk("ill_done_keep", 32'(done), 32'd1);
      tick();

      // Reload retention
      bq = '{8'h8C, 8'hC4, 8'h00, 8'h01, 8'hAC, 8'hC4, 8'h00, 8'h02};
      load(2, bq, 20);
      bq = '{8'h20, 8'h07, 8'h00, 8'h07};
      load(1, bq, 30);
      index = 0;
      @(negedge clk);
      chk("reload_w0", instr, 32'h2007_0007);
      index = 1;
      @(negedge clk);
      chk("reload_w1", instr, 32'hACC4_0002);
      index = 16;
      @(negedge clk);
      chk("reload_idx16", instr, 32'h0);
      tick();

      // Random loads
      for (int r = 0; r < 6; r++) begin
         c = $urandom_range(1, 16);
         bq.delete();
         for (int i = 0; i < 4 * c; i++) bq.push_back(8'($urandom));
         load(c, bq, $urandom_range(0, 70));
         sweep($sformatf("rand%0d", r));
      end

      // Start and reset mid-load
      issue_start(3);
      bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send(bq, 25);
      model[0] = 32'h1122_3344;
      start = 1'b1;
      count = 5'd2;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      tick();
      start = 1'b0;
      index = 0;
      @(negedge clk);
      chk("mid_ready", 32'(in_ready), 32'd1);
      chk("mid_w0", instr, 32'h1122_3344);
      index = 1;
      @(negedge clk);
      chk("mid_w1_old", instr, model[1]);
      tick();
      do_reset();
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      tick();
      sweep("midrst");
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
